// File: rtl/simplecpu_loader.sv
// Wishbone slave owning simplecpu's RAM load port and run/reset control.
// Firmware queues (addr, byte) pairs; the block halts the CPU, writes them into RAM, then releases it on request.
module simplecpu_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              cpu_reset_o,
  output logic              load_ram_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic [DATA_W-1:0] load_data_o,
  input  logic [DATA_W-1:0] out_port_i,
  output logic              irq_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int HC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALT,
    ST_HALTED,
    ST_SETUP,
    ST_WRITE
  } state_t;

  state_t            state, state_d;
  logic [HC_W-1:0]   hcnt;
  logic              hcnt_done;
  logic              run_take;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              fifo_full, fifo_nempty, push, pop;

  logic              run_pend, ovf;
  logic [DATA_W-1:0] out_q;
  logic [15:0]       chg_cnt;

  logic              wb_req, wb_wr, data_wr, ctrl_wr;
  logic              halt_w, run_w, clr_w;
  logic [1:0]        reg_sel;
  logic [31:0]       rd_val;
  logic              cpu_running, busy;
  logic              unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:ENT_W]};

  // A request is a new strobe that has not been acked yet; writes land on the edge that raises ack.
  assign wb_req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wb_wr   = wb_req & wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign data_wr = wb_wr && (reg_sel == 2'd0);
  assign ctrl_wr = wb_wr && (reg_sel == 2'd1);
  assign halt_w  = ctrl_wr & wbs_dat_i[1];
  assign run_w   = ctrl_wr & wbs_dat_i[0];
  assign clr_w   = ctrl_wr & wbs_dat_i[2];

  // Full is judged on the pre-pop count, so a push into a full FIFO drops even while draining.
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_nempty = (count != '0);
  assign push        = data_wr & ~fifo_full;
  assign pop         = (state == ST_WRITE);
  assign head        = mem[rd_ptr];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wbs_dat_i[ENT_W-1:0];
  end

  assign hcnt_done   = (hcnt == HC_W'(RST_CYCLES - 1));
  assign cpu_running = (state == ST_RUN);
  assign busy        = fifo_nempty || (state == ST_HALT) || (state == ST_SETUP) || (state == ST_WRITE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_HALTED;
      hcnt  <= '0;
    end else begin
      state <= state_d;
      hcnt  <= (state == ST_HALT) ? hcnt + HC_W'(1) : '0;
    end
  end

  always_comb begin
    state_d  = state;
    run_take = 1'b0;
    case (state)
      ST_RUN: begin
        if (fifo_nempty || halt_w) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (hcnt_done) state_d = fifo_nempty ? ST_SETUP : ST_HALTED;
      end
      ST_HALTED: begin
        if (fifo_nempty) begin
          state_d = ST_SETUP;
        end else if (run_pend && !halt_w) begin
          state_d  = ST_RUN;
          run_take = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: state_d = (count > CNT_W'(1)) ? ST_SETUP : ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  assign cpu_reset_o = (state != ST_RUN);
  assign load_ram_o  = (state == ST_WRITE);
  assign irq_o       = ovf;

  // Address/data are latched during SETUP and stay put through the strobe and beyond.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      load_addr_o <= '0;
      load_data_o <= '0;
    end else if (state == ST_SETUP) begin
      load_addr_o <= head[ENT_W-1:DATA_W];
      load_data_o <= head[DATA_W-1:0];
    end
  end

  // A CTRL write beats the automatic clear taken on release; halt beats run.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      run_pend <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (halt_w)        run_pend <= 1'b0;
      else if (run_w)    run_pend <= 1'b1;
      else if (run_take) run_pend <= 1'b0;

      if (data_wr && fifo_full) ovf <= 1'b1;
      else if (clr_w)           ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q   <= '0;
      chg_cnt <= '0;
    end else begin
      out_q <= out_port_i;
      if (cpu_running && (out_port_i != out_q)) chg_cnt <= chg_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd1: rd_val[2:0] = {ovf, cpu_running, run_pend};
      2'd2: begin
        rd_val[0]    = busy;
        rd_val[1]    = cpu_running;
        rd_val[2]    = ovf;
        rd_val[7:4]  = 4'(count);
        rd_val[15:8] = 8'(out_q);
      end
      2'd3: begin
        rd_val[7:0]   = 8'(out_q);
        rd_val[31:16] = chg_cnt;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_simplecpu_loader.sv
// Randomized bench for simplecpu_loader against a queue-based reference model, plus directed literal checks.
// A long halt window is used so back-to-back pushes can actually overflow the FIFO.
module tb_simplecpu_loader;

  localparam int DEPTH = 4;
  localparam int RSTC  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cpu_reset, load_ram, irq;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;
  logic [7:0]  out_port = '0;

  always #5 clk = ~clk;

  simplecpu_loader #(.FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC), .ADDR_W(4), .DATA_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cpu_reset_o(cpu_reset), .load_ram_o(load_ram),
    .load_addr_o(load_addr), .load_data_o(load_data),
    .out_port_i(out_port), .irq_o(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in a queue, the CPU either running, sitting out a halt countdown,
  // or stepping through a two-phase write of the queue head.
  logic [11:0] q[$];
  bit          m_running, m_run_pend, m_ovf, m_ack;
  int          m_halt_left, m_phase;
  logic [31:0] m_dat, m_rv;
  logic [3:0]  m_la;
  logic [7:0]  m_ld, m_outq;
  logic [15:0] m_chg;
  bit          m_req, m_dwr, m_cwr, m_halt_w, m_run_w, m_clr_w, m_full, m_take, m_pop, m_was_run, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_running = 0; m_run_pend = 0; m_ovf = 0; m_ack = 0;
      m_halt_left = 0; m_phase = 0;
      m_dat = '0; m_la = '0; m_ld = '0; m_outq = '0; m_chg = '0;
    end else begin
      m_req    = stb && cyc && !m_ack;
      m_dwr    = m_req && we && (adr[3:2] == 2'd0);
      m_cwr    = m_req && we && (adr[3:2] == 2'd1);
      m_halt_w = m_cwr && wdat[1];
      m_run_w  = m_cwr && wdat[0];
      m_clr_w  = m_cwr && wdat[2];
      m_full   = (q.size() >= DEPTH);
      m_was_run = m_running;
      m_busy   = (q.size() > 0) || (m_halt_left > 0) || (m_phase != 0);
      case (adr[3:2])
        2'd1:    m_rv = {29'b0, m_ovf, m_running, m_run_pend};
        2'd2:    m_rv = {16'b0, m_outq, 4'(q.size()), 1'b0, m_ovf, m_running, m_busy};
        2'd3:    m_rv = {m_chg, 8'b0, m_outq};
        default: m_rv = 32'd0;
      endcase
      m_take = 0;
      m_pop  = 0;
      if (m_running) begin
        if (q.size() > 0 || m_halt_w) begin
          m_running   = 0;
          m_halt_left = RSTC;
        end
      end else if (m_halt_left > 0) begin
        m_halt_left--;
        if (m_halt_left == 0 && q.size() > 0) m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_la = q[0][11:8];
        m_ld = q[0][7:0];
      end else if (m_phase == 2) begin
        m_phase = (q.size() > 1) ? 1 : 0;
        m_pop = 1;
      end else if (q.size() > 0) begin
        m_phase = 1;
      end else if (m_run_pend && !m_halt_w) begin
        m_running = 1;
        m_take = 1;
      end
      if (m_pop) void'(q.pop_front());
      if (m_dwr) begin
        if (m_full) m_ovf = 1;
        else q.push_back(wdat[11:0]);
      end
      if (m_clr_w) m_ovf = 0;
      if (m_halt_w)     m_run_pend = 0;
      else if (m_run_w) m_run_pend = 1;
      else if (m_take)  m_run_pend = 0;
      if (m_was_run && out_port != m_outq) m_chg = m_chg + 16'd1;
      m_outq = out_port;
      m_dat  = (m_req && !we) ? m_rv : 32'd0;
      m_ack  = m_req;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cpu_reset", cpu_reset, !m_running);
      checkOutput("load_ram", load_ram, m_phase == 2);
      checkOutput("load_addr", load_addr, m_la);
      checkOutput("load_data", load_data, m_ld);
      checkOutput("wb_ack", ack, m_ack);
      checkOutput("wb_dat", rdat, m_dat);
      checkOutput("irq", irq, m_ovf);
    end
  end

  logic [11:0] wlog[$];
  always @(negedge clk) begin
    if (rst_n && load_ram) wlog.push_back({load_addr, load_data});
  end

  function automatic logic [31:0] logAt(input int i);
    return (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic applyStimulus(input bit wr, input logic [1:0] sel, input logic [31:0] d,
                               output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = wr;
    adr = {28'($urandom), sel, 2'($urandom)};
    wdat = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    checkOutput("wb_ack_seen", ack, 1'b1);
    rd = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wbWrite(input logic [1:0] sel, input logic [31:0] d);
    logic [31:0] dummy;
    applyStimulus(1'b1, sel, d, dummy);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitRun();
    int n;
    n = 0;
    while (cpu_reset && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("run_reached", cpu_reset, 1'b0);
  endtask

  logic [31:0] rd;
  int          ctrl_tab[8] = '{1, 1, 1, 2, 4, 3, 5, 0};

  initial begin
    $display("[TB] start");
    waitCycles(3);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset state
    checkOutput("reset_cpu_reset", cpu_reset, 1'b1);
    applyStimulus(1'b0, 2'd2, 32'd0, rd);
    checkOutput("status_after_reset", rd, 32'h0);

    // Load two bytes then run
    wlog.delete();
    wbWrite(2'd0, 32'h3A5);
    wbWrite(2'd0, 32'h0F1);
    wbWrite(2'd1, 32'h1);
    waitRun();
    checkOutput("load_count", wlog.size(), 2);
    checkOutput("load_first", logAt(0), 32'h3A5);
    checkOutput("load_second", logAt(1), 32'h0F1);
    applyStimulus(1'b0, 2'd2, 32'd0, rd);
    checkOutput("status_running", rd[1], 1'b1);

    // Push while running: halts, writes, stays halted
    wlog.delete();
    wbWrite(2'd0, 32'h522);
    waitCycles(RSTC + 12);
    checkOutput("push_run_write", logAt(0), 32'h522);
    checkOutput("push_run_halted", cpu_reset, 1'b1);
    applyStimulus(1'b0, 2'd1, 32'd0, rd);
    checkOutput("push_run_ctrl", rd, 32'h0);

    // Overflow with back-to-back pushes during the halt window
    wbWrite(2'd1, 32'h1);
    waitRun();
    wlog.delete();
    for (int i = 1; i <= 6; i++) wbWrite(2'd0, 32'(i * 32'h101));
    waitCycles(RSTC + 16);
    checkOutput("ovf_count", wlog.size(), 4);
    checkOutput("ovf_first", logAt(0), 32'h101);
    checkOutput("ovf_fourth", logAt(3), 32'h404);
    checkOutput("ovf_irq", irq, 1'b1);
    applyStimulus(1'b0, 2'd1, 32'd0, rd);
    checkOutput("ovf_ctrl", rd, 32'h4);
    wbWrite(2'd1, 32'h4);
    checkOutput("ovf_cleared", irq, 1'b0);

    // Halt overrides run
    wbWrite(2'd1, 32'h3);
    waitCycles(10);
    checkOutput("halt_prio_reset", cpu_reset, 1'b1);
    applyStimulus(1'b0, 2'd1, 32'd0, rd);
    checkOutput("halt_prio_ctrl", rd, 32'h0);

    // Change counter and wrap
    wbWrite(2'd1, 32'h1);
    waitRun();
    out_port = 8'h00; waitCycles(1);
    out_port = 8'h01; waitCycles(1);
    out_port = 8'h01; waitCycles(1);
    out_port = 8'h02; waitCycles(1);
    applyStimulus(1'b0, 2'd3, 32'd0, rd);
    checkOutput("chg_two", rd, 32'h0002_0002);
    for (int i = 0; i < 65533; i++) begin
      @(posedge clk); #1;
      out_port = out_port ^ 8'h01;
    end
    applyStimulus(1'b0, 2'd3, 32'd0, rd);
    checkOutput("chg_max", rd, 32'hFFFF_0003);
    out_port = out_port ^ 8'h01;
    applyStimulus(1'b0, 2'd3, 32'd0, rd);
    checkOutput("chg_wrap", rd, 32'h0000_0002);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) out_port = 8'($urandom);
      if (op < 4)      wbWrite(2'd0, $urandom);
      else if (op < 6) wbWrite(2'd1, {29'($urandom), 3'(ctrl_tab[$urandom_range(0, 7)])});
      else if (op < 8) applyStimulus(1'b0, 2'($urandom_range(0, 3)), $urandom, rd);
      else             waitCycles($urandom_range(1, 4));
    end

    // Asynchronous reset in the middle of a RAM write strobe
    out_port = 8'h00;
    wbWrite(2'd1, 32'h2);
    wbWrite(2'd0, 32'h7C3);
    wbWrite(2'd0, 32'h811);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!load_ram && n < 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("strobe_seen", load_ram, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_load_ram", load_ram, 1'b0);
    checkOutput("async_cpu_reset", cpu_reset, 1'b1);
    waitCycles(2);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(1'b0, 2'd2, 32'd0, rd);
    checkOutput("status_after_async", rd, 32'h0);

    waitCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simplecpu_loader.md
Name: simplecpu_loader

Overview:
- Wishbone-slave controller that owns the simplecpu program-load port and run/reset control. Replaces direct logic-analyzer driving of load_ram/load_addr/load_data/reset.
- Firmware pushes (addr, byte) pairs into a small FIFO. The block halts the CPU, writes each pair into CPU RAM with a setup/strobe sequence, then releases the CPU on request.
- Also samples the CPU output port and counts its changes for firmware readback.

Parameters:
- FIFO_DEPTH, 4, write-FIFO entries; power of 2, minimum 2.
- RST_CYCLES, 4, cycles cpu_reset_o is held before the first RAM write after a halt; minimum 1.
- ADDR_W, 4, CPU RAM address width.
- DATA_W, 8, CPU RAM data width and out_port width.

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_adr_i  in  32  byte address; only [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  read data.
- cpu_reset_o  out  1  active-high reset to simplecpu.
- load_ram_o  out  1  RAM write strobe to simplecpu.
- load_addr_o  out  ADDR_W  RAM write address.
- load_data_o  out  DATA_W  RAM write data.
- out_port_i  in  DATA_W  simplecpu output port, same clock domain.
- irq_o  out  1  level; equals the overflow sticky bit.

Behaviour:
- Reset (async assert, sync release):
  - state=HALTED; cpu_reset_o=1; load_ram_o=0; load_addr_o=0; load_data_o=0.
  - FIFO empty; ovf=0; run_pend=0; wbs_ack_o=0; wbs_dat_o=0; out_q=0; chg_cnt=0; irq_o=0.
- Wishbone timing:
  - stb&cyc&!ack -> ack=1 next cycle for exactly one cycle. Ack never deasserts stb.
  - Writes take effect in the ack cycle. Read data is registered and valid with ack.
  - wbs_sel_i is not used; full-word access only.
- Register map (adr[3:2]):
  - 0 DATA (W): [11:8]=addr, [7:0]=data; pushes one FIFO entry. If FIFO is full at the write: still acked, entry dropped, ovf<=1. Full is evaluated before any same-cycle pop. Read returns 0.
  - 1 CTRL (W): bit0 run -> run_pend<=1; bit1 halt -> run_pend<=0 and force halt; bit2 clr_ovf -> ovf<=0. halt overrides run when both are set. Read returns {29'b0, ovf, cpu_running, run_pend}.
  - 2 STATUS (R): [0] busy (FIFO non-empty or state in {HALT, SETUP, WRITE}); [1] cpu_running (state==RUN); [2] ovf; [7:4] FIFO count; [15:8] out_q.
  - 3 OUT (R): [7:0] out_q; [31:16] chg_cnt.
- State machine:
  - RUN: cpu_reset_o=0. FIFO non-empty or halt write -> HALT with a cleared counter.
  - HALT: cpu_reset_o=1; count RST_CYCLES cycles. Then FIFO non-empty -> SETUP, else -> HALTED.
  - HALTED: cpu_reset_o=1. FIFO non-empty -> SETUP. Else run_pend -> RUN and clear run_pend.
  - SETUP: load_addr_o/load_data_o <= FIFO head; load_ram_o=0; 1 cycle -> WRITE.
  - WRITE: load_ram_o=1 for exactly 1 cycle with addr/data stable; pop FIFO. FIFO still non-empty -> SETUP, else -> HALTED. run_pend release is then taken from HALTED, so the cost is 1 extra cycle.
- Timing and ordering:
  - Per-entry write cost is 2 cycles.
  - load_addr_o/load_data_o hold their last value outside SETUP/WRITE.
  - RAM writes occur only while cpu_reset_o=1. A push during RUN always halts the CPU first.
  - Halt write during SETUP/WRITE: no effect on the sequence beyond clearing run_pend.
  - Push in the same cycle as a pop: count unchanged, both honoured (unless full, per the DATA rule).
- Output capture:
  - out_q <= out_port_i every cycle.
  - chg_cnt (16 bit, wraps 0xFFFF->0) increments when state==RUN and out_port_i != out_q.
- Count field width: clog2(FIFO_DEPTH)+1, zero-extended into [7:4].

Test Plan:
- Reset: wb_rst_ni low mid-WRITE -> load_ram_o=0 and cpu_reset_o=1 immediately (async). After release, STATUS reads 0x00000000.
- Load and run: push 0x3A5, 0x0F1, then CTRL=1 -> two SETUP/WRITE pairs with load_ram_o pulses at addr 3 data 0xA5, then addr 0 data 0xF1. cpu_reset_o falls 1 cycle after the second WRITE. STATUS[1]=1.
- Push while running: in RUN, push 0x522 -> cpu_reset_o=1 for RST_CYCLES=4 cycles, then write addr 5 data 0x22. CPU stays in HALTED (run_pend clear); a second CTRL=1 required.
- Overflow: with CPU in RUN, push 6 entries back-to-back with FIFO_DEPTH=4 -> 4 written in order. ovf=1 and irq_o=1. CTRL=4 clears both.
- Halt priority: CTRL=3 while HALTED with empty FIFO -> stays HALTED; run_pend=0.
- Change counter: in RUN, drive out_port_i 0x00,0x01,0x01,0x02 -> OUT[31:16]=2, OUT[7:0]=0x02. Preload chg_cnt at 0xFFFF by forcing 65535 changes -> next change wraps to 0.
